// File: rtl/io_pkg.sv
// Shared constants, state encoding and request payload for the CPU port responder.
package io_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PORT_LED    = 8'd0;
  localparam logic [BYTE_W-1:0] PORT_LINK   = 8'd1;
  localparam logic [BYTE_W-1:0] PORT_STATUS = 8'd2;

  // Bit positions inside the IN 2 status byte; the low nibble reads as zero.
  localparam int unsigned STAT_TX_FULL  = 7;
  localparam int unsigned STAT_TX_EMPTY = 6;
  localparam int unsigned STAT_RX_FULL  = 5;
  localparam int unsigned STAT_RX_EMPTY = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [BYTE_W-1:0] port;
    logic [BYTE_W-1:0] wdata;
  } io_req_t;

  function automatic logic [BYTE_W-1:0] status_byte(input logic tx_full,
                                                     input logic tx_empty,
                                                     input logic rx_full,
                                                     input logic rx_empty);
    logic [BYTE_W-1:0] s;
    s                = '0;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_RX_EMPTY] = rx_empty;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop frees the slot for a same-cycle push when full.
module byte_fifo
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [BYTE_W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_port_responder.sv
// Responder for CPU OUT/IN port requests: LED latch, byte link FIFOs, switches and status.
module io_port_responder
  import io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [BYTE_W-1:0] port,
  input  logic [BYTE_W-1:0] wdata,
  output logic              ack,
  output logic [BYTE_W-1:0] rdata,
  output logic [BYTE_W-1:0] out0,
  input  logic [BYTE_W-1:0] sw_in,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              err
);

  state_t            state;
  io_req_t           req_q;
  logic [BYTE_W-1:0] sync_q [SYNC_STAGES];

  logic              tx_full;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [BYTE_W-1:0] rx_head;

  logic is_led_wr_c;
  logic is_tx_wr_c;
  logic is_sw_rd_c;
  logic is_rx_rd_c;
  logic is_stat_rd_c;
  logic mapped_c;
  logic stall_c;
  logic tx_push_c;
  logic rx_push_c;
  logic rx_pop_c;

  // Decode of the captured request; only acted on while in SERVE.
  assign is_led_wr_c  =  req_q.wr && (req_q.port == PORT_LED);
  assign is_tx_wr_c   =  req_q.wr && (req_q.port == PORT_LINK);
  assign is_sw_rd_c   = !req_q.wr && (req_q.port == PORT_LED);
  assign is_rx_rd_c   = !req_q.wr && (req_q.port == PORT_LINK);
  assign is_stat_rd_c = !req_q.wr && (req_q.port == PORT_STATUS);
  assign mapped_c     = is_led_wr_c || is_tx_wr_c || is_sw_rd_c || is_rx_rd_c || is_stat_rd_c;

  // A full tx FIFO still accepts the write when the link drains its head this cycle.
  assign stall_c   = (is_tx_wr_c && tx_full && !tx_ready) || (is_rx_rd_c && rx_empty);
  assign tx_push_c = (state == SERVE) && is_tx_wr_c && !stall_c;
  assign rx_pop_c  = (state == SERVE) && is_rx_rd_c && !stall_c;
  assign rx_push_c = rx_valid && rx_ready;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;
  assign rx_ready = !rx_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_c),
    .wdata (req_q.wdata),
    .pop   (tx_ready),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push_c),
    .wdata (rx_data),
    .pop   (rx_pop_c),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  // Switch input synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Request handshake FSM with registered ack/err/rdata/out0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      out0  <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            req_q.wr    <= wr;
            req_q.port  <= port;
            req_q.wdata <= wdata;
            state       <= SERVE;
          end
        end
        SERVE: begin
          if (!stall_c) begin
            ack   <= 1'b1;
            state <= ACK;
            if (is_led_wr_c)  out0  <= req_q.wdata;
            if (is_sw_rd_c)   rdata <= sync_q[SYNC_STAGES-1];
            if (is_rx_rd_c)   rdata <= rx_head;
            if (is_stat_rd_c) rdata <= status_byte(tx_full, tx_empty, rx_full, rx_empty);
            if (!mapped_c) begin
              rdata <= '0;
              err   <= 1'b1;
            end
          end
        end
        ACK: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // A req still held from the finished transfer must drop before the next one.
          if (!req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: queue-based port/FIFO model, directed and random requests.
module tb_io_port_responder;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] port = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] sw_in = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       ack;
  logic       err;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] rdata;
  logic [7:0] out0;
  logic [7:0] tx_data;

  io_port_responder #(.FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wr       (wr),
    .port     (port),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .out0     (out0),
    .sw_in    (sw_in),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       chk_rdata;
    logic       err;
    logic [7:0] out0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] out0_m = 8'h00;
  logic [7:0] sw_hist [16];
  logic [7:0] rx_future = 8'h00;
  int         rx_owed = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         ack_cnt = 0;
  exp_t       mon_e;
  logic [7:0] mon_tx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] status_m();
    return {tx_q.size() == D, tx_q.size() == 0, rx_q.size() == D, rx_q.size() == 0, 4'b0000};
  endfunction

  // Switch value present at each rising edge, indexed by edge count.
  always @(posedge clk) begin
    cyc = cyc + 1;
    sw_hist[4'(cyc)] = sw_in;
  end

  // Response monitor: every ack is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (err) chk("err_with_ack", 32'(ack), 32'd1);
    if (ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: rdata %0h err %0b with nothing outstanding", rdata, err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_err", 32'(err), 32'(mon_e.err));
        if (mon_e.chk_rdata) chk("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
        chk("ack_out0", 32'(out0), 32'(mon_e.out0));
      end
    end
  end

  // Link monitor: each byte leaving the tx FIFO must be the oldest one written.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra: got %0h with no byte outstanding", tx_data);
      end else begin
        mon_tx = tx_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(mon_tx));
      end
    end
  end

  task automatic do_req(input logic w, input logic [7:0] p, input logic [7:0] d,
                        input int exp_lat, input int hold, input logic [8:0] sw_chg);
    exp_t e;
    int   lat;
    bit   seen;
    @(posedge clk);
    #1;
    e.err       = 1'b0;
    e.chk_rdata = 1'b0;
    e.rdata     = 8'h00;
    if (w && p == 8'd0) begin
      out0_m = d;
    end else if (w && p == 8'd1) begin
      tx_q.push_back(d);
    end else if (!w && p == 8'd0) begin
      // IN 0 sees the switches as they stood S-1 edges before req is sampled.
      e.chk_rdata = 1'b1;
      e.rdata     = sw_hist[4'(cyc + 2 - S)];
    end else if (!w && p == 8'd1) begin
      e.chk_rdata = 1'b1;
      if (rx_q.size() > 0) begin
        e.rdata = rx_q.pop_front();
      end else begin
        e.rdata = rx_future;
        rx_owed++;
      end
    end else if (!w && p == 8'd2) begin
      e.chk_rdata = 1'b1;
      e.rdata     = status_m();
    end else begin
      e.chk_rdata = 1'b1;
      e.err       = 1'b1;
    end
    e.out0 = out0_m;
    exp_q.push_back(e);
    if (sw_chg[8]) sw_in = sw_chg[7:0];
    wr    = w;
    port  = p;
    wdata = d;
    req   = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL req_timeout: port %0d wr %0b got no ack within %0d cycles", p, w, lat);
    end else if (exp_lat > 0) begin
      chk("ack_latency", 32'(lat), 32'(exp_lat));
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    req   = 1'b0;
    wr    = 1'b0;
    port  = 8'h00;
    wdata = 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_push_timeout: rx_ready got 0 want 1");
    end else begin
      @(posedge clk);
      #1;
      if (rx_owed > 0) rx_owed--;
      else rx_q.push_back(b);
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    int n;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    tx_ready = 1'b0;
    chk("tx_drained", 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int op;
    logic [7:0] r;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);

    do_req(1'b1, 8'd0, 8'hA5, 2, 0, 9'h000);
    chk("out0_led", 32'(out0), 32'hA5);

    sw_in = 8'h3C;
    repeat (4) @(posedge clk);
    do_req(1'b0, 8'd0, 8'h00, 2, 0, 9'h000);
    do_req(1'b0, 8'd0, 8'h00, 2, 0, 9'h1C3);
    do_req(1'b0, 8'd0, 8'h00, 2, 0, 9'h000);

    for (int i = 0; i < 4; i++) rx_push(8'h11 + 8'(i));
    chk("rx_full_ready", 32'(rx_ready), 32'd0);
    do_req(1'b0, 8'd2, 8'h00, 2, 0, 9'h000);
    for (int i = 0; i < 4; i++) do_req(1'b0, 8'd1, 8'h00, 2, 0, 9'h000);
    rx_future = 8'h55;
    a0 = ack_cnt;
    fork
      do_req(1'b0, 8'd1, 8'h00, 0, 0, 9'h000);
      begin
        repeat (8) @(posedge clk);
        chk("rx_stall_no_ack", 32'(ack_cnt), 32'(a0));
        rx_push(8'h55);
      end
    join

    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_req(1'b1, 8'd1, 8'(i), 2, 0, 9'h000);
    do_req(1'b0, 8'd2, 8'h00, 2, 0, 9'h000);
    a0 = ack_cnt;
    fork
      do_req(1'b1, 8'd1, 8'h05, 0, 0, 9'h000);
      begin
        repeat (6) @(posedge clk);
        chk("tx_stall_no_ack", 32'(ack_cnt), 32'(a0));
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
      end
    join
    chk("tx_head_second", 32'(tx_data), 32'h02);
    drain_tx();

    do_req(1'b1, 8'd7, 8'h99, 2, 0, 9'h000);
    chk("unmapped_out0_kept", 32'(out0), 32'hA5);
    do_req(1'b0, 8'd9, 8'h00, 2, 0, 9'h000);

    a0 = ack_cnt;
    do_req(1'b0, 8'd2, 8'h00, 2, 10, 9'h000);
    repeat (5) @(posedge clk);
    chk("held_req_one_ack", 32'(ack_cnt - a0), 32'd1);

    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 6));
      r  = 8'($urandom);
      case (op)
        0: do_req(1'b1, 8'd0, r, 2, 0, 9'h000);
        1: if (tx_q.size() < D) do_req(1'b1, 8'd1, r, 2, 0, 9'h000);
           else drain_tx();
        2: begin
          @(posedge clk);
          #1 sw_in = r;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_req(1'b0, 8'd0, 8'h00, 2, 0, {1'($urandom), 8'($urandom)});
        end
        3: if (rx_q.size() > 0) do_req(1'b0, 8'd1, 8'h00, 2, 0, 9'h000);
           else rx_push(r);
        4: do_req(1'b0, 8'd2, 8'h00, 2, 0, 9'h000);
        5: if (rx_q.size() < D) rx_push(r);
           else do_req(1'b0, 8'd1, 8'h00, 2, 0, 9'h000);
        default: begin
          if ($urandom_range(0, 1) == 1) do_req(1'b1, 8'($urandom_range(2, 255)), r, 2, 0, 9'h000);
          else do_req(1'b0, 8'($urandom_range(3, 255)), 8'h00, 2, 0, 9'h000);
        end
      endcase
    end
    drain_tx();

    do_req(1'b1, 8'd0, 8'h5A, 2, 0, 9'h000);
    do_req(1'b1, 8'd1, 8'h77, 2, 0, 9'h000);
    while (rx_q.size() > 0) do_req(1'b0, 8'd1, 8'h00, 2, 0, 9'h000);
    @(posedge clk);
    #1;
    wr   = 1'b0;
    port = 8'd1;
    req  = 1'b1;
    a0   = ack_cnt;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req   = 1'b0;
    port  = 8'h00;
    rst_n = 1'b1;
    tx_q.delete();
    rx_q.delete();
    out0_m = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_abandon_no_ack", 32'(ack_cnt), 32'(a0));
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mid_out0", 32'(out0), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    do_req(1'b0, 8'd2, 8'h00, 2, 0, 9'h000);
    do_req(1'b1, 8'd0, 8'h3E, 2, 0, 9'h000);

    repeat (5) @(posedge clk);
    chk("all_acks_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
Responder end of the CPU's OUT/IN port interface. The CPU acts as initiator and issues port requests over a req/ack handshake. This block decodes the port number and serves each request:
- OUT: latches the byte to an LED register or pushes it into a transmit FIFO.
- IN: returns synchronized switch inputs, pops a receive FIFO, or returns status.
It sits beside the RAM on the CPU's clock domain and feeds the LED scan and an external byte link.

Parameters:
FIFO_DEPTH, 4, entries per FIFO; must be a power of two, minimum 2
SYNC_STAGES, 2, flops in the sw_in synchronizer chain

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  synchronous active-low reset
req  in  1  request from CPU; held high until ack seen
wr  in  1  1 = OUT (write), 0 = IN (read); stable while req high
port  in  8  port number; stable while req high
wdata  in  8  OUT data; stable while req high
ack  out  1  one-cycle completion pulse
rdata  out  8  IN result; valid in ack cycle, held until next ack
out0  out  8  OUT port 0 latch (drives LED row)
sw_in  in  8  asynchronous switch inputs
rx_valid  in  1  upstream byte available
rx_data  in  8  upstream byte
rx_ready  out  1  rx FIFO not full
tx_valid  out  1  tx FIFO not empty
tx_data  out  8  tx FIFO head byte
tx_ready  in  1  downstream accepts head byte
err  out  1  one-cycle pulse with ack when port is unmapped

Behaviour:
- Reset (rst_n low at clk edge):
  - Outputs: ack=0, err=0, rdata=0, out0=0.
  - Both FIFOs empty, so tx_valid=0 and rx_ready=1.
  - Synchronizer flops cleared; state=IDLE.
  - Reset mid-request abandons the request; no ack is issued for it.
- Port map:
  - OUT 0: out0 <= wdata.
  - OUT 1: push wdata into tx FIFO.
  - IN 0: rdata <= synchronized sw_in.
  - IN 1: pop rx FIFO head into rdata.
  - IN 2: rdata <= {tx_full, tx_empty, rx_full, rx_empty, 4'b0}.
  - Any other port/direction: ack with rdata=0, err=1, no side effects.
- State machine IDLE -> SERVE -> ACK -> RELEASE -> IDLE:
  - IDLE: on req=1, capture wr, port and wdata into registers; go to SERVE.
  - SERVE: if serviceable, perform the action and go to ACK. Otherwise stay in SERVE (stall, no timeout). Stall cases:
    - OUT 1 while tx FIFO is full.
    - IN 1 while rx FIFO is empty.
  - ACK: ack=1 (and err if unmapped) for exactly one cycle; go to RELEASE.
  - RELEASE: wait for req=0, then go to IDLE. A held-high req is never served twice.
- Latency: req sampled at edge N gives ack at edge N+2 minimum. Stall cycles add to this.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits; they wrap naturally.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - External push: rx_valid && rx_ready.
  - External pop: tx_valid && tx_ready.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured and count is unchanged. This includes a full FIFO, where a pop frees the slot used by the push.
  - An empty FIFO with push+pop does not bypass: the pop is invalid, and the byte appears the next cycle.
- sw_in passes through SYNC_STAGES flops before use; an IN 0 reads the value from the last stage.

Decomposition:
- Shared package io_pkg holds:
  - Port number constants: PORT_LED=0, PORT_LINK=1, PORT_STATUS=2.
  - State encodings: IDLE, SERVE, ACK, RELEASE.
  - The status bit positions.
- One sub-module, byte_fifo (parameter DEPTH; push/pop/full/empty/head), instantiated twice, for rx and tx.

Test Plan:
- Reset then OUT port0 wdata=0xA5 -> ack 2 cycles after req, out0=0xA5, err=0.
- IN port0 with sw_in=0x3C steady -> rdata=0x3C in ack cycle; sw_in change <SYNC_STAGES cycles before req is not seen.
- Push 4 bytes 0x11..0x14 via rx, then IN port1 x5:
  - First four return 0x11..0x14 in order.
  - Fifth stalls with no ack until rx pushes 0x55, then returns 0x55.
- With tx_ready=0, OUT port1 x5:
  - Fifth stalls and tx status reads full.
  - Raising tx_ready for one cycle yields ack and tx_data=0x02 (second byte) next.
- OUT port 7 -> ack with err=1, rdata=0, out0 unchanged.
- Hold req high for 10 cycles -> exactly one ack. Assert rst_n=0 during SERVE stall -> no ack, FIFOs empty, out0=0.
